maxnet_controller: RTL and testbench

- Control FSM for the 4-neuron Maxnet datapath. It sequences initial activation load, the 4x4 row/column MAC sweep, the register update and the convergence check.
- It drives the datapath's ld1..ld4, initCounter1/2 and enCounter1/2, and consumes the datapath's counter carries Co1/Co2 and its convergence flag.
- It sits directly upstream of the datapath. It reports completion, timeout and iteration count to the top level.

---
 rtl/maxnet_controller_if.sv | 39 +++
 rtl/maxnet_controller.sv | 107 ++++++++++
 tb/tb_maxnet_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/maxnet_controller_if.sv
// Control/status bundle between the Maxnet controller and the rest of the
// Maxnet core (datapath counters, convergence flag, run handshake).
interface maxnet_controller_if #(
    parameter int ITER_W = 5
);
    logic              start;
    logic              Co1;
    logic              Co2;
    logic              oneLeft;
    logic              ld1;
    logic              ld2;
    logic              ld3;
    logic              ld4;
    logic              selInit;
    logic              initCounter1;
    logic              initCounter2;
    logic              enCounter1;
    logic              enCounter2;
    logic              accEn;
    logic              wrNew;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ITER_W-1:0] iter;

    // Controller side
    modport master (
        input  start, Co1, Co2, oneLeft,
        output ld1, ld2, ld3, ld4, selInit, initCounter1, initCounter2,
               enCounter1, enCounter2, accEn, wrNew, busy, done, timeout, iter
    );

    // Datapath / top-level side
    modport slave (
        output start, Co1, Co2, oneLeft,
        input  ld1, ld2, ld3, ld4, selInit, initCounter1, initCounter2,
               enCounter1, enCounter2, accEn, wrNew, busy, done, timeout, iter
    );
endinterface

// File: rtl/maxnet_controller.sv
// Maxnet control FSM: loads the initial activations, sweeps the 4x4 weight
// matrix row by row, commits the new activations and repeats until exactly
// one neuron survives or the iteration limit is hit.
module maxnet_controller #(
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    maxnet_controller_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_ld;
    logic              r_sel_init;
    logic              r_init_cnt;
    logic              r_acc_en;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic [ITER_W-1:0] r_iter;

    // Next-state decision; Moore outputs are then registered from it so they
    // line up exactly with the state they belong to.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_MAC;
            S_MAC:    if (bus.Co1 && bus.Co2) w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_CHECK;
            S_CHECK:  w_state_next = (bus.oneLeft || (r_iter == MAX_ITER_C)) ? S_DONE : S_MAC;
            S_DONE:   if (!bus.start) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register, registered strobes and the iteration/timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ld       <= '0;
            r_sel_init <= 1'b0;
            r_init_cnt <= 1'b0;
            r_acc_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_iter     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ld       <= {4{(w_state_next == S_LOAD) || (w_state_next == S_UPDATE)}};
            r_sel_init <= (w_state_next == S_LOAD);
            r_init_cnt <= (w_state_next == S_LOAD) || (w_state_next == S_UPDATE);
            r_acc_en   <= (w_state_next == S_MAC);
            r_busy     <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
            r_done     <= (w_state_next == S_DONE);
            case (r_state)
                S_LOAD: begin
                    r_iter    <= '0;
                    r_timeout <= 1'b0;
                end
                S_UPDATE: r_iter <= r_iter + 1'b1;
                // Convergence wins over the iteration limit on the same cycle.
                S_CHECK:  r_timeout <= !bus.oneLeft && (r_iter == MAX_ITER_C);
                S_DONE: begin
                    // Leaving for IDLE: status returns to zero there.
                    if (!bus.start) begin
                        r_iter    <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld1          = r_ld[0];
    assign bus.ld2          = r_ld[1];
    assign bus.ld3          = r_ld[2];
    assign bus.ld4          = r_ld[3];
    assign bus.selInit      = r_sel_init;
    assign bus.initCounter1 = r_init_cnt;
    assign bus.initCounter2 = r_init_cnt;
    assign bus.enCounter2   = r_acc_en;
    assign bus.accEn        = r_acc_en;
    // Row advance and new-value write happen at the end of each column sweep.
    assign bus.enCounter1   = r_acc_en & bus.Co2;
    assign bus.wrNew        = r_acc_en & bus.Co2;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.timeout      = r_timeout;
    assign bus.iter         = r_iter;

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller with a small row/column counter
// model standing in for the datapath.
module tb_maxnet_controller;

    localparam int ITER_W   = 5;
    localparam int MAX_ITER = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxnet_controller_if #(.ITER_W(ITER_W)) bus ();

    maxnet_controller #(
        .MAX_ITER(MAX_ITER),
        .ITER_W  (ITER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- datapath model ----------------
    logic [1:0] row = 2'd0;
    logic [1:0] col = 2'd0;
    int         upd_seen = 0;
    int         conv_after = 0;   // 0 = never converge
    logic       start_drv = 1'b0;

    always @(posedge clk) begin
        if (bus.initCounter1) row <= 2'd0;
        else if (bus.enCounter1) row <= row + 2'd1;
        if (bus.initCounter2) col <= 2'd0;
        else if (bus.enCounter2) col <= col + 2'd1;
        if (bus.ld1 && bus.selInit) upd_seen <= 0;
        else if (bus.ld1 && !bus.selInit) upd_seen <= upd_seen + 1;
    end

    assign bus.Co1     = (row == 2'd3);
    assign bus.Co2     = (col == 2'd3);
    assign bus.oneLeft = (conv_after != 0) && (upd_seen >= conv_after);
    assign bus.start   = start_drv;

    // ---------------- scoreboard ----------------
    typedef struct {
        int   cycles;
        int   iters;
        logic to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int outs_word();
        return int'({bus.ld1, bus.ld2, bus.ld3, bus.ld4, bus.selInit,
                     bus.initCounter1, bus.initCounter2, bus.enCounter1,
                     bus.enCounter2, bus.accEn, bus.wrNew, bus.busy,
                     bus.done, bus.timeout, bus.iter});
    endfunction

    // Monitor: counts strobes per run and checks a finished run against the queue.
    logic done_q  = 1'b0;
    bit   running = 1'b0;
    int   cyc, acc_n, wr_n, upd_n;

    always @(negedge clk) begin
        exp_t e;
        if (bus.ld1 && bus.selInit) begin
            running = 1'b1;
            cyc = 0; acc_n = 0; wr_n = 0; upd_n = 0;
        end else if (running) begin
            cyc++;
        end
        if (bus.accEn) acc_n++;
        if (bus.wrNew) wr_n++;
        if (bus.ld1 && !bus.selInit) upd_n++;
        if (bus.done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("run done: cycles=%0d iter=%0d timeout=%0b (expect %0d/%0d/%0b)",
                         cyc, bus.iter, bus.timeout, e.cycles, e.iters, e.to);
                check("done_cycles",  cyc, e.cycles);
                check("done_iter",    int'(bus.iter), e.iters);
                check("done_timeout", int'(bus.timeout), int'(e.to));
                check("done_busy",    int'(bus.busy), 0);
                check("acc_cycles",   acc_n, 16 * e.iters);
                check("wrnew_pulses", wr_n, 4 * e.iters);
                check("update_lds",   upd_n, e.iters);
            end
            running = 1'b0;
        end
        done_q = bus.done;
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int budget);
        int k = 0;
        while (!bus.done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", int'(bus.done), 1);
    endtask

    task automatic issue_start(input int conv, input int cycles, input int iters,
                               input logic to, input bit hold);
        exp_t e;
        e.cycles = cycles; e.iters = iters; e.to = to;
        conv_after = conv;
        exp_q.push_back(e);
        start_drv = 1'b1;
        @(negedge clk);
        check("load_strobes", int'({bus.ld1, bus.ld2, bus.ld3, bus.ld4, bus.selInit,
                                    bus.initCounter1, bus.initCounter2}), 7'h7F);
        if (!hold) start_drv = 1'b0;
        wait_done(200);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", outs_word(), 0);
        end

        // Single-iteration convergence
        issue_start(1, 19, 1, 1'b0, 1'b0);
        @(negedge clk);
        check("return_idle", outs_word(), 0);

        // Three iterations
        issue_start(3, 55, 3, 1'b0, 1'b0);
        @(negedge clk);
        check("return_idle", outs_word(), 0);

        // Iteration-limit timeout
        issue_start(0, 73, 4, 1'b1, 1'b0);
        @(negedge clk);
        check("return_idle", outs_word(), 0);

        // Convergence arrives on the same CHECK as the limit
        issue_start(4, 73, 4, 1'b0, 1'b0);
        @(negedge clk);
        check("return_idle", outs_word(), 0);

        // Mid-run reset
        conv_after = 1;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (5) @(negedge clk);
        check("in_mac", int'({bus.busy, bus.accEn}), 3);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_run", outs_word(), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_after_reset", outs_word(), 0);
        end

        // Start held through DONE: exactly one run
        issue_start(1, 19, 1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done", int'({bus.done, bus.busy, bus.ld1}), 3'b100);
        end
        start_drv = 1'b0;
        @(negedge clk);
        check("release_idle", outs_word(), 0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
